// File: rtl/vedic_mult_pipe_if.sv
// Streaming handshake bundle for vedic_mult_pipe: operand pair in, product out,
// each side with its own valid/ready pair.
interface vedic_mult_pipe_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_signed,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_product
  );

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_signed,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_product
  );
endinterface

// File: rtl/vedic_mult_pipe.sv
// Pipelined Urdhva-Tiryakbhyam multiplier: sign-magnitude front end, 2x2 vedic
// cells, one register level per recursive recombination, then sign restore.
module vedic_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  vedic_mult_pipe_if.slave bus
);

  localparam int unsigned LG      = $clog2(WIDTH);
  localparam int unsigned LATENCY = LG + 2;
  localparam int unsigned HALF    = WIDTH / 2;
  // All recombination levels packed back to back; level l holds
  // (WIDTH>>l)^2 products of 2^(l+1) bits each.
  localparam int unsigned LVW     = 2 * WIDTH * WIDTH - 2 * WIDTH;

  typedef logic [LVW-1:0]     lv_t;
  typedef logic [2*WIDTH-1:0] dbl_t;

  logic                adv;
  logic [WIDTH-1:0]    s0_a;
  logic [WIDTH-1:0]    s0_b;
  logic [LATENCY-2:0]  vld_q;
  logic [LATENCY-2:0]  neg_q;
  lv_t                 lv_q;
  lv_t                 lv_d;
  dbl_t                p_final;
  logic                out_valid_q;
  dbl_t                out_product_q;

  function automatic int unsigned lv_off(input int unsigned l);
    return 2 * WIDTH * WIDTH - ((4 * WIDTH * WIDTH) >> l);
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                           input logic             sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  // Exact 2x2 vedic cell: vertical, crosswise, vertical with the crosswise carry.
  function automatic logic [3:0] cell2(input logic [1:0] a, input logic [1:0] b);
    logic vh;
    logic c1;
    vh = a[1] & b[1];
    c1 = a[1] & b[0] & a[0] & b[1];
    return {vh & c1, vh ^ c1, (a[1] & b[0]) ^ (a[0] & b[1]), a[0] & b[0]};
  endfunction

  function automatic dbl_t quarter(input lv_t v, input int unsigned pos,
                                   input int unsigned w);
    return dbl_t'(v >> pos) & ((dbl_t'(1) << w) - dbl_t'(1));
  endfunction

  // Product (i,j) of level l from the four level l-1 products it spans.
  function automatic dbl_t merge(input lv_t v, input int unsigned l,
                                 input int unsigned i, input int unsigned j);
    int unsigned qw;
    int unsigned pd;
    int unsigned base;
    dbl_t hh;
    dbl_t hl;
    dbl_t lh;
    dbl_t ll;
    qw   = 1 << l;
    pd   = WIDTH >> (l - 1);
    base = lv_off(l - 1);
    hh   = quarter(v, base + ((2*i + 1) * pd + 2*j + 1) * qw, qw);
    hl   = quarter(v, base + ((2*i + 1) * pd + 2*j) * qw, qw);
    lh   = quarter(v, base + ((2*i) * pd + 2*j + 1) * qw, qw);
    ll   = quarter(v, base + ((2*i) * pd + 2*j) * qw, qw);
    return (hh << qw) + ((hl + lh) << (qw / 2)) + ll;
  endfunction

  assign adv             = !out_valid_q || bus.out_ready;
  assign bus.in_ready    = adv;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_product = out_product_q;

  always_comb begin
    lv_d = '0;
    for (int unsigned i = 0; i < HALF; i++) begin
      for (int unsigned j = 0; j < HALF; j++) begin
        lv_d = lv_d | (lv_t'(cell2(s0_a[2*i +: 2], s0_b[2*j +: 2])) << (4 * (i * HALF + j)));
      end
    end
    for (int unsigned l = 2; l <= LG; l++) begin
      for (int unsigned i = 0; i < (WIDTH >> l); i++) begin
        for (int unsigned j = 0; j < (WIDTH >> l); j++) begin
          lv_d = lv_d | (lv_t'(merge(lv_q, l, i, j))
                         << (lv_off(l) + (i * (WIDTH >> l) + j) * (2 << l)));
        end
      end
    end
  end

  assign p_final = dbl_t'(lv_q >> lv_off(LG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_a          <= '0;
      s0_b          <= '0;
      vld_q         <= '0;
      neg_q         <= '0;
      lv_q          <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[LATENCY-3:0], bus.in_valid};
      neg_q <= {neg_q[LATENCY-3:0],
                bus.in_valid & bus.in_signed & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1])};
      if (bus.in_valid) begin
        s0_a <= mag(bus.in_a, bus.in_signed);
        s0_b <= mag(bus.in_b, bus.in_signed);
      end
      lv_q          <= lv_d;
      out_valid_q   <= vld_q[LATENCY-2];
      out_product_q <= neg_q[LATENCY-2] ? -p_final : p_final;
    end
  end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Randomised and directed bench for vedic_mult_pipe at WIDTH=8 and WIDTH=2,
// with queue-based scoreboards fed by the drivers and drained by monitors.
module tb_vedic_mult_pipe;

  localparam int unsigned LAT8 = 5;
  localparam int unsigned LAT2 = 3;

  typedef struct {
    logic [15:0] p;
    int unsigned cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  exp_t q8[$];
  exp_t q2[$];
  bit stall8 = 1'b0;
  logic [15:0] held8 = '0;
  bit rnd_done = 1'b0;

  vedic_mult_pipe_if #(.WIDTH(8)) bus8 ();
  vedic_mult_pipe_if #(.WIDTH(2)) bus2 ();

  vedic_mult_pipe #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  vedic_mult_pipe #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: ordinary integer multiplication of the operands as interpreted.
  function automatic longint model(input longint a, input longint b, input int w, input bit s);
    if (s && ((a >> (w - 1)) & 1) != 0) a = a - (longint'(1) << w);
    if (s && ((b >> (w - 1)) & 1) != 0) b = b - (longint'(1) << w);
    return a * b;
  endfunction

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit s,
                       input logic [15:0] e, input bit lat);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus8.in_valid = 1'b1; bus8.in_a = a; bus8.in_b = b; bus8.in_signed = s;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus8.in_ready) begin
        q8.push_back('{p: e, cyc: cyc, lat: lat});
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("accept8_timeout", 0, 1);
  endtask

  task automatic send8m(input logic [7:0] a, input logic [7:0] b, input bit s, input bit lat);
    send8(a, b, s, 16'(model(longint'(a), longint'(b), 8, s)), lat);
  endtask

  task automatic idle8();
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic send2(input logic [1:0] a, input logic [1:0] b, input bit s);
    logic [3:0] e;
    bit ok;
    ok = 1'b0;
    e = 4'(model(longint'(a), longint'(b), 2, s));
    @(posedge clk); #1;
    bus2.in_valid = 1'b1; bus2.in_a = a; bus2.in_b = b; bus2.in_signed = s;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus2.in_ready) begin
        q2.push_back('{p: 16'(e), cyc: cyc, lat: 1'b1});
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("accept2_timeout", 0, 1);
  endtask

  task automatic drain8();
    for (int k = 0; k < 300 && q8.size() != 0; k++) @(posedge clk);
    check("drain8_pending", q8.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall8 = 1'b0;
    end else begin
      if (stall8) begin
        check("hold_valid8", bus8.out_valid, 1);
        check("hold_product8", bus8.out_product, held8);
      end
      if (bus8.out_valid && !bus8.out_ready) check("stall_in_ready8", bus8.in_ready, 0);
      if (bus8.out_valid && bus8.out_ready) begin
        if (q8.size() == 0) begin
          check("spurious_out8", bus8.out_product, -1);
        end else begin
          exp_t e;
          e = q8.pop_front();
          check("product8", bus8.out_product, e.p);
          if (e.lat) check("latency8", cyc - e.cyc, LAT8);
        end
      end
      stall8 = bus8.out_valid && !bus8.out_ready;
      held8  = bus8.out_product;
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus2.out_valid && bus2.out_ready) begin
      if (q2.size() == 0) begin
        check("spurious_out2", bus2.out_product, -1);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check("product2", bus2.out_product, e.p);
        if (e.lat) check("latency2", cyc - e.cyc, LAT2);
      end
    end
  end

  initial begin
    bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0; bus8.in_signed = 1'b0;
    bus8.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_signed = 1'b0;
    bus2.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_out_valid8", bus8.out_valid, 0);
    check("reset_product8", bus8.out_product, 0);
    check("reset_out_valid2", bus2.out_valid, 0);
    check("reset_product2", bus2.out_product, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset8", bus8.in_ready, 1);
    check("in_ready_after_reset2", bus2.in_ready, 1);

    // Directed values with expectations written out by hand.
    send8(8'd255, 8'd255, 1'b0, 16'hFE01, 1'b1);
    idle8();
    drain8();
    send8(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
    send8(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b1);
    send8(8'h7F, 8'hFF, 1'b1, 16'hFF81, 1'b1);
    send8(8'h00, 8'hF9, 1'b1, 16'h0000, 1'b1);
    send8(8'h80, 8'h7F, 1'b1, 16'hC080, 1'b1);
    idle8();
    drain8();

    for (int i = 0; i < 16; i++) send8m(8'(i), 8'(i + 1), 1'b0, 1'b1);
    idle8();
    drain8();

    fork
      begin
        for (int i = 0; i < 20; i++) send8m(8'(40 + 7 * i), 8'(200 - 3 * i), 1'b0, 1'b0);
        idle8();
      end
      begin
        repeat (9) @(posedge clk);
        #1 bus8.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus8.out_ready = 1'b1;
      end
    join
    drain8();

    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          if ($urandom_range(0, 4) == 0) idle8();
          else send8m(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        idle8();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus8.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus8.out_ready = 1'b1;
      end
    join
    drain8();

    // Asynchronous reset with results both presented and still in flight.
    for (int i = 0; i < 7; i++) send8m(8'(i + 9), 8'(i + 5), 1'b0, 1'b1);
    idle8();
    #1;
    check("pre_reset_out_valid8", bus8.out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_out_valid8", bus8.out_valid, 0);
    check("async_reset_product8", bus8.out_product, 0);
    q8.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    send8(8'd2, 8'd3, 1'b0, 16'h0006, 1'b1);
    idle8();
    drain8();

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++) send2(2'(a), 2'(b), 1'(s));
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    for (int k = 0; k < 100 && q2.size() != 0; k++) @(posedge clk);
    check("drain2_pending", q2.size(), 0);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/vedic_mult_pipe.md
Name: vedic_mult_pipe

Overview:
- Parametrised, pipelined Urdhva-Tiryakbhyam (vedic) multiplier for WIDTH x WIDTH operands, producing a 2*WIDTH product.
- Built recursively from 2x2 vedic cells, with one register level per recombination step.
- Supports per-transaction signed or unsigned operation.
- Uses valid/ready handshakes on both sides, so it sits directly in streaming datapaths (filters, MAC front-ends) between producer and consumer blocks.

Parameters:
- WIDTH, 8, operand width; power of two, >= 2.
- LATENCY (localparam), log2(WIDTH)+2, accepted-input to out_valid cycles with no stall.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
- out_valid  output  1  out_product valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_product  output  2*WIDTH  product, two's-complement when the transaction was signed.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n=0): all stage valid bits, out_valid and out_product clear to 0 immediately. Data registers also clear to 0. in_ready is 1 one cycle after rst_n deasserts.
- Global advance: adv = !out_valid | out_ready. All stages shift together when adv=1 and hold when adv=0. in_ready = adv (combinational).
- Transfer rules:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - Bubbles (stages with valid=0) shift through like data. No bubble collapsing.
- Stage 0 (input register):
  - Capture in_signed.
  - Capture magnitudes |a| and |b|. In signed mode, negate when the MSB is set; in unsigned mode pass the value through.
  - Capture neg = in_signed & (a[MSB] ^ b[MSB]).
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits in WIDTH unsigned bits.
- Stage 1: compute all (WIDTH/2)^2 2x2 sub-products with the vedic cell:
  - p0 = a0b0
  - p1 = a1b0 ^ a0b1
  - p2 = a1b1 ^ (a1b0 & a0b1 & a0b1-carry); this must equal the full 2x2 product bits 2..3
  - Sub-products are registered at exactly 4 bits.
  - Required: every 2x2 cell is arithmetically exact, e.g. 3*3 = 9 = 4'b1001.
- Stages 2..log2(WIDTH), one per doubling:
  - Combine four n-bit quarter products into one 2n-bit product: P = (HH << n) + ((HL + LH) << n/2) + LL.
  - Middle sum is n+1 bits wide; no truncation before the final 2n-bit result.
  - For WIDTH=2 this range is empty.
- Final stage: out_product = neg ? -P : P, registered; out_valid is set with it.
- Ordering: results emerge strictly in acceptance order. No loss or duplication under any out_ready pattern.
- Stall: while out_valid=1 and out_ready=0, out_product and out_valid hold bit-stable and in_ready=0.
- Simultaneous in/out transfer in the same cycle with the pipeline full: both occur, giving a throughput of one result per cycle.
- Reset mid-operation: all in-flight transactions are discarded and out_valid drops asynchronously. After reset, no stale result is ever emitted.
- Operand inputs are ignored when in_valid=0 or in_ready=0.

Test Plan:
- WIDTH=8, unsigned: 255*255, out_ready=1 -> out_product=16'hFE01 with out_valid exactly 5 cycles after acceptance.
- WIDTH=8, signed: -128*-128 -> 16'h4000; -3*5 -> 16'hFFF1; 127*-1 -> 16'hFF81; signed 0*-7 -> 16'h0000.
- WIDTH=8, stream of 16 back-to-back pairs (a=i, b=i+1, unsigned), out_ready=1 -> 16 consecutive results i*(i+1) on 16 consecutive cycles, in order.
- Backpressure: stream running, out_ready=0 for 3 cycles mid-burst:
  - out_product and out_valid are held.
  - in_ready=0 during the stall.
  - After release, the full sequence is intact with no gaps or duplicates.
- Reset: assert rst_n=0 with 3 transactions in flight -> out_valid=0 immediately. After release, the first new pair 2*3 yields 16'h0006 and no earlier value appears.
- WIDTH=2, exhaustive 16 combinations, both modes:
  - Unsigned 3*3 = 4'b1001.
  - Signed -1*-1 = 4'b0001.
  - Signed -2*1 = 4'b1110.
  - Latency 3 for all combinations.
